mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle multiply/divide unit for the execute stage, operating alongside the single-cycle ALU. It takes the same `dataA`/`dataB` operands and the 6-bit `Signal` function code from the decode stage. MULTU/DIVU are computed iteratively over 32 cycles into architectural HI/LO registers. MFHI/MFLO read HI/LO onto `dataOut` for the writeback mux.

## Interface
- `WIDTH`, 32: operand width. HI and LO are each WIDTH bits.
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `valid` input 1: issue strobe. Qualifies `Signal`/`dataA`/`dataB` for starting an operation.
- `Signal` input 6: function code.
  - MULTU = 6'b011001
  - DIVU = 6'b011011
  - MFHI = 6'b010000
  - MFLO = 6'b010010
  - MULT = 6'b011000 and DIV = 6'b011010 only under config.
- `dataA` input WIDTH: multiplicand or dividend.
- `dataB` input WIDTH: multiplier or divisor.
- `dataOut` output WIDTH: combinational. HI when `Signal`==MFHI, LO when MFLO, else 0.
- `busy` output 1: high while an operation is iterating.
- `done` output 1: registered, one-cycle pulse when HI/LO have been updated.
- `divZero` output 1: registered. Set with `done` when the finished op was a divide with `dataB`==0; cleared at the next accept.

## Operation
- States: IDLE, MUL, DIV. 5-bit iteration counter `count`.
- Accept: `valid`=1, state IDLE, `Signal` is a start code.
  - Latch operands into working registers; count=0; go to MUL or DIV.
- Ignored without effect:
  - `valid` with a non-start code.
  - `valid` while state is MUL or DIV.
- MUL, shift-add:
  - 65-bit working product {carry, P_hi, P_lo}; P_lo is initialised to the multiplier.
  - Each cycle: if P_lo[0], add the multiplicand to P_hi with carry out; then shift the whole product right 1.
- DIV, restoring:
  - Working remainder R (WIDTH+1 bits) and quotient Q; Q is initialised to the dividend.
  - Each cycle: shift {R,Q} left 1 and subtract the divisor from R.
  - If the result is negative, restore R and set Q[0]=0; otherwise keep the result and set Q[0]=1.
- Completion, when count==31 in MUL or DIV:
  - Write HI/LO. MUL: HI=upper product, LO=lower product. DIV: HI=remainder, LO=quotient.
  - Pulse `done`; return to IDLE.
- Divide by zero:
  - Runs the full 32 iterations.
  - Result is forced to HI=dividend, LO={WIDTH{1'b1}}, with `divZero`=1.
- HI/LO change only at completion. MFHI/MFLO during `busy` return the previous result.
- Working registers are never visible on `dataOut`.
- Reset values: HI=0, LO=0, `busy`=0, `done`=0, `divZero`=0, state IDLE, count=0.
- Reset mid-operation: aborts immediately, all outputs return to their reset values, the partial result is discarded.

## Timing
- Accept at edge T. `busy`=1 from T until edge T+32.
- Iterations occur on edges T+1..T+32.
- At edge T+32: HI/LO are written, `done` rises, `busy` falls, state returns to IDLE.
- `done` is high for exactly one cycle, between edges T+32 and T+33. Latency from accept to `done` is 32 cycles.
- Back-to-back issue: a `valid` presented while `done` is high is accepted at edge T+33.
- `dataOut` is purely combinational from `Signal` and HI/LO.
  - A result is readable in the cycle `done` is high.
  - A read of HI/LO in the same cycle as an accept returns the old HI/LO.

## Configuration
- `MULDIV_SIGNED_EN` defined: MULT and DIV are start codes.
  - Operands are converted to magnitudes at accept and the 32-cycle core is unchanged.
  - At completion: product negated if sign(A)^sign(B); quotient negated if sign(A)^sign(B); remainder takes the sign of A.
  - Divide by zero gives HI=dataA, LO=all ones.
- `MULDIV_SIGNED_EN` undefined: MULT and DIV are ignored like any non-start code. Only unsigned logic is synthesised.

## Test plan
- Max unsigned multiply:
  - MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF.
  - Expect `done` 32 cycles after accept, then HI=0xFFFFFFFE, LO=0x00000001.
- Unsigned divide:
  - DIVU, A=100, B=7.
  - Expect LO=14, HI=2, `divZero`=0.
- Divide by zero:
  - DIVU, A=5, B=0.
  - Expect LO=0xFFFFFFFF, HI=5, `divZero`=1 with `done`.
  - The next accepted op clears `divZero`.
- Issue while busy, and back-to-back:
  - Prior result HI=0, LO=6. Issue MULTU 3×4.
  - At cycle 5 of the op, issue MULTU 9×9: it is ignored.
  - MFHI/MFLO during `busy` read 0 and 6.
  - At `done`: LO=12.
  - Issue DIVU in the `done` cycle: it is accepted.
- Reset mid-operation:
  - Assert `reset` at iteration 10 of DIVU 1000/3.
  - Expect all outputs 0 asynchronously.
  - Then MULTU 2×3 gives LO=6, HI=0.
- `MULDIV_SIGNED_EN` defined:
  - MULT −3×5 gives HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV −7/2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- `MULDIV_SIGNED_EN` undefined: MULT with `valid` leaves `busy`=0 and HI/LO unchanged.

Source files
------------

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Multi-cycle multiply/divide unit for the execute stage. MULTU
//            and DIVU iterate for 32 cycles (shift-add / restoring divide)
//            into the architectural HI/LO registers. MFHI/MFLO place HI/LO
//            onto dataOut for the writeback mux.
// Ports    : clk      - clock, rising edge
//            reset    - asynchronous active-high reset
//            valid    - issue strobe qualifying Signal/dataA/dataB
//            Signal   - 6-bit function code
//            dataA    - multiplicand / dividend
//            dataB    - multiplier / divisor
//            dataOut  - combinational HI (MFHI), LO (MFLO), else 0
//            busy     - high while an operation is iterating
//            done     - one-cycle pulse when HI/LO have been updated
//            divZero  - set with done when the finished divide had dataB==0
// Config   : MULDIV_SIGNED_EN - when defined, MULT/DIV are start codes and
//            operate on signed operands via magnitude conversion.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    localparam logic [5:0] c_op_multu = 6'b011001;
    localparam logic [5:0] c_op_divu  = 6'b011011;
    localparam logic [5:0] c_op_mfhi  = 6'b010000;
    localparam logic [5:0] c_op_mflo  = 6'b010010;
`ifdef MULDIV_SIGNED_EN
    localparam logic [5:0] c_op_mult  = 6'b011000;
    localparam logic [5:0] c_op_div   = 6'b011010;
`endif

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;

    logic [1:0]         r_state;
    logic [4:0]         r_count;
    logic [WIDTH-1:0]   r_mcand;      // multiplicand magnitude
    logic [2*WIDTH-1:0] r_prod;       // {P_hi, P_lo}; carry lives only inside one step
    logic [WIDTH:0]     r_rem;        // restoring-divide remainder
    logic [WIDTH-1:0]   r_quo;        // quotient, starts as dividend
    logic [WIDTH-1:0]   r_dvsr;       // divisor magnitude
    logic [WIDTH-1:0]   r_dvnd;       // raw dataA, returned as HI on divide by zero
    logic               r_dz;         // current divide has a zero divisor
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divzero;
`ifdef MULDIV_SIGNED_EN
    logic               r_neg_q;      // product/quotient must be negated
    logic               r_neg_r;      // remainder must be negated
`endif

    logic               w_start_mul;
    logic               w_start_div;
    logic               w_accept;
    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic [WIDTH:0]     w_mul_add;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [WIDTH+1:0]   w_rem_sh;
    logic [WIDTH+1:0]   w_diff;
    logic               w_neg;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    // ------------------------------------------------------------------
    // Start decode and operand conditioning
    // ------------------------------------------------------------------
`ifdef MULDIV_SIGNED_EN
    logic w_sign_op;
    logic w_a_neg;
    logic w_b_neg;

    assign w_sign_op   = (Signal == c_op_mult) || (Signal == c_op_div);
    assign w_start_mul = (Signal == c_op_multu) || (Signal == c_op_mult);
    assign w_start_div = (Signal == c_op_divu)  || (Signal == c_op_div);
    assign w_a_neg     = w_sign_op & dataA[WIDTH-1];
    assign w_b_neg     = w_sign_op & dataB[WIDTH-1];
    // The iterative core only ever sees magnitudes.
    assign w_opa       = w_a_neg ? (~dataA + 1'b1) : dataA;
    assign w_opb       = w_b_neg ? (~dataB + 1'b1) : dataB;
`else
    assign w_start_mul = (Signal == c_op_multu);
    assign w_start_div = (Signal == c_op_divu);
    assign w_opa       = dataA;
    assign w_opb       = dataB;
`endif

    assign w_accept = valid && (r_state == c_st_idle) && (w_start_mul || w_start_div);

    // ------------------------------------------------------------------
    // Shift-add multiply step: optional add into P_hi with carry, then the
    // carry/P_hi/P_lo triple shifts right by one.
    // ------------------------------------------------------------------
    assign w_mul_add  = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                                  :  {1'b0, r_prod[2*WIDTH-1:WIDTH]};
    assign w_prod_nxt = {w_mul_add, r_prod[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // Restoring divide step. One extra bit on the difference acts as the
    // borrow, so a set MSB means the trial subtraction went negative.
    // ------------------------------------------------------------------
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_rem_sh - {2'b00, r_dvsr};
    assign w_neg     = w_diff[WIDTH+1];
    assign w_rem_nxt = w_neg ? w_rem_sh[WIDTH:0] : w_diff[WIDTH:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_neg};

    // ------------------------------------------------------------------
    // Final result as written into HI/LO on the last iteration
    // ------------------------------------------------------------------
    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        if (r_state == c_st_mul) begin
            {w_res_hi, w_res_lo} = w_prod_nxt;
`ifdef MULDIV_SIGNED_EN
            if (r_neg_q) begin
                {w_res_hi, w_res_lo} = ~w_prod_nxt + 1'b1;
            end
`endif
        end else if (r_dz) begin
            w_res_hi = r_dvnd;
            w_res_lo = {WIDTH{1'b1}};
        end else begin
            w_res_hi = w_rem_nxt[WIDTH-1:0];
            w_res_lo = w_quo_nxt;
`ifdef MULDIV_SIGNED_EN
            if (r_neg_r) begin
                w_res_hi = ~w_rem_nxt[WIDTH-1:0] + 1'b1;
            end
            if (r_neg_q) begin
                w_res_lo = ~w_quo_nxt + 1'b1;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_count   <= '0;
            r_mcand   <= '0;
            r_prod    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_dvnd    <= '0;
            r_dz      <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_count   <= '0;
                        r_divzero <= 1'b0;
                        r_mcand   <= w_opa;
                        r_prod    <= {{WIDTH{1'b0}}, w_opb};
                        r_rem     <= '0;
                        r_quo     <= w_opa;
                        r_dvsr    <= w_opb;
                        r_dvnd    <= dataA;
                        r_dz      <= (dataB == '0);
`ifdef MULDIV_SIGNED_EN
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
`endif
                        r_state   <= w_start_mul ? c_st_mul : c_st_div;
                    end
                end
                c_st_mul: begin
                    r_prod  <= w_prod_nxt;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_done  <= 1'b1;
                        r_state <= c_st_idle;
                    end
                end
                c_st_div: begin
                    r_rem   <= w_rem_nxt;
                    r_quo   <= w_quo_nxt;
                    r_count <= r_count + 5'd1;
                    if (r_count == 5'd31) begin
                        r_hi      <= w_res_hi;
                        r_lo      <= w_res_lo;
                        r_done    <= 1'b1;
                        r_divzero <= r_dz;
                        r_state   <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        dataOut = '0;
        if (Signal == c_op_mfhi) begin
            dataOut = r_hi;
        end else if (Signal == c_op_mflo) begin
            dataOut = r_lo;
        end
    end

    assign busy    = (r_state != c_st_idle);
    assign done    = r_done;
    assign divZero = r_divzero;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed self-checking bench for mul_div_unit with
//            hand-computed expected HI/LO, latency and flag values.
//            Define MULDIV_SIGNED_EN to exercise the signed build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    localparam logic [5:0] c_op_multu = 6'b011001;
    localparam logic [5:0] c_op_divu  = 6'b011011;
    localparam logic [5:0] c_op_mfhi  = 6'b010000;
    localparam logic [5:0] c_op_mflo  = 6'b010010;
    localparam logic [5:0] c_op_mult  = 6'b011000;
    localparam logic [5:0] c_op_div   = 6'b011010;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataOut;
    logic        busy;
    logic        done;
    logic        divZero;

    int n_cmp = 0;
    int n_bad = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .Signal  (Signal),
        .dataA   (dataA),
        .dataB   (dataB),
        .dataOut (dataOut),
        .busy    (busy),
        .done    (done),
        .divZero (divZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents one issue cycle; returns at the falling edge after the accept edge.
    task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Signal = sig;
        dataA  = a;
        dataB  = b;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
    endtask

    // Counts falling edges until done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        Signal = c_op_mfhi;
        #1 hi = dataOut;
        Signal = c_op_mflo;
        #1 lo = dataOut;
    endtask

    initial begin
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        seen;

        reset  = 1'b1;
        valid  = 1'b0;
        Signal = 6'd0;
        dataA  = '0;
        dataB  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_divzero", {31'd0, divZero}, 32'd0);
        read_hilo(hi, lo);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Max unsigned multiply
        issue(c_op_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulmax_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check("mulmax_latency", cyc, 32'd32);
        read_hilo(hi, lo);
        check("mulmax_hi", hi, 32'hFFFF_FFFE);
        check("mulmax_lo", lo, 32'h0000_0001);
        check("mulmax_divzero", {31'd0, divZero}, 32'd0);
        @(negedge clk);
        check("mulmax_done_pulse", {31'd0, done}, 32'd0);
        check("mulmax_idle", {31'd0, busy}, 32'd0);

        // Divide by zero, then the next accept clears divZero
        issue(c_op_divu, 32'd5, 32'd0);
        wait_done(cyc);
        check("dz_latency", cyc, 32'd32);
        check("dz_flag", {31'd0, divZero}, 32'd1);
        read_hilo(hi, lo);
        check("dz_hi", hi, 32'd5);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        issue(c_op_multu, 32'd2, 32'd3);
        check("dz_cleared", {31'd0, divZero}, 32'd0);
        wait_done(cyc);
        read_hilo(hi, lo);
        check("mul23_hi", hi, 32'd0);
        check("mul23_lo", lo, 32'd6);

        // Issue while busy is ignored; old HI/LO visible while busy
        issue(c_op_multu, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        Signal = c_op_multu;
        dataA  = 32'd9;
        dataB  = 32'd9;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        check("busy_still", {31'd0, busy}, 32'd1);
        read_hilo(hi, lo);
        check("busy_read_hi", hi, 32'd0);
        check("busy_read_lo", lo, 32'd6);
        wait_done(cyc);
        check("busy_latency", cyc + 5, 32'd32);
        read_hilo(hi, lo);
        check("mul34_hi", hi, 32'd0);
        check("mul34_lo", lo, 32'd12);

        // Back-to-back: DIVU issued during the done cycle
        Signal = c_op_divu;
        dataA  = 32'd100;
        dataB  = 32'd7;
        valid  = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        check("b2b_accept", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done(cyc);
        check("div_latency", cyc, 32'd32);
        check("div_divzero", {31'd0, divZero}, 32'd0);
        read_hilo(hi, lo);
        check("div_hi", hi, 32'd2);
        check("div_lo", lo, 32'd14);

        // Reset mid-operation
        issue(c_op_divu, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        Signal = c_op_mflo;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_divzero", {31'd0, divZero}, 32'd0);
        check("midrst_lo", dataOut, 32'd0);
        Signal = c_op_mfhi;
        #1;
        check("midrst_hi", dataOut, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(c_op_multu, 32'd2, 32'd3);
        wait_done(cyc);
        check("postrst_latency", cyc, 32'd32);
        read_hilo(hi, lo);
        check("postrst_hi", hi, 32'd0);
        check("postrst_lo", lo, 32'd6);

`ifdef MULDIV_SIGNED_EN
        issue(c_op_mult, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc);
        check("smul_latency", cyc, 32'd32);
        read_hilo(hi, lo);
        check("smul_hi", hi, 32'hFFFF_FFFF);
        check("smul_lo", lo, 32'hFFFF_FFF1);
        issue(c_op_div, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        check("sdiv_latency", cyc, 32'd32);
        read_hilo(hi, lo);
        check("sdiv_hi", hi, 32'hFFFF_FFFF);
        check("sdiv_lo", lo, 32'hFFFF_FFFD);
`else
        issue(c_op_mult, 32'd7, 32'd7);
        check("mult_ignored_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        check("mult_ignored_activity", {31'd0, seen}, 32'd0);
        read_hilo(hi, lo);
        check("mult_ignored_hi", hi, 32'd0);
        check("mult_ignored_lo", lo, 32'd6);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
